// File: rtl/shift_issue_stage.sv
// Issue/retire stage around an external combinational shifter (SLL/SRA).
// Requests queue in a small FIFO. The FIFO head drives the shifter from
// registers, and the shifter result is captured into an output register.
// The result is then offered to the consumer over a valid/ready handshake.
module shift_issue_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_operand,
  input  logic [4:0]               in_shamt,
  input  logic                     in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [31:0]              sh_data_operand,
  output logic [4:0]               sh_ctrl_shiftamt,
  output logic                     sh_op,
  input  logic [31:0]              sh_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]      operand;
    logic [4:0]       shamt;
    logic             op;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t             fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             out_valid_q;
  logic [31:0]      out_result_q;
  logic [TAG_W-1:0] out_tag_q;

  logic push;
  logic head_valid;
  logic out_load;
  req_t head;

  // Handshake decode. in_ready depends only on registered occupancy.
  always_comb begin
    in_ready   = (count_q < CNT_W'(DEPTH));
    push       = in_valid & in_ready;
    head_valid = (count_q != '0);
    out_load   = head_valid & (~out_valid_q | out_ready);
    head       = fifo_q[rd_ptr_q];
  end

  // Occupancy next-state. Simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, out_load})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointers. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{operand: in_operand, shamt: in_shamt, op: in_op, tag: in_tag};
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (out_load) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Result register: load from the shifter on retire, otherwise drain when consumed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (out_load) begin
      out_valid_q  <= 1'b1;
      out_result_q <= sh_result;
      out_tag_q    <= head.tag;
    end else if (out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  // The shifter sees the head entry straight from storage. When the FIFO is empty,
  // the stale slot contents are don't-care.
  assign sh_data_operand  = head.operand;
  assign sh_ctrl_shiftamt = head.shamt;
  assign sh_op            = head.op;

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign count      = count_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage with an external shifter model.
module tb_shift_issue_stage;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned TAG_W = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_operand;
  logic [4:0]        in_shamt;
  logic              in_op;
  logic [TAG_W-1:0]  in_tag;
  logic [31:0]       sh_data_operand;
  logic [4:0]        sh_ctrl_shiftamt;
  logic              sh_op;
  logic [31:0]       sh_result;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [TAG_W-1:0]  out_tag;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];
  int          got_cyc[$];

  shift_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_operand       (in_operand),
    .in_shamt         (in_shamt),
    .in_op            (in_op),
    .in_tag           (in_tag),
    .sh_data_operand  (sh_data_operand),
    .sh_ctrl_shiftamt (sh_ctrl_shiftamt),
    .sh_op            (sh_op),
    .sh_result        (sh_result),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_tag          (out_tag),
    .count            (count)
  );

  always #5 clock = ~clock;

  // External combinational shifter.
  assign sh_result = sh_op ? 32'($signed(sh_data_operand) >>> sh_ctrl_shiftamt)
                           : (sh_data_operand << sh_ctrl_shiftamt);

  // Reference shift: one bit position at a time.
  function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [4:0] s,
                                            input logic sra);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < int'(s); i++) begin
      r = sra ? {r[31], r[31:1]} : {r[30:0], 1'b0};
    end
    return r;
  endfunction

  // Record accepted requests (as expected results) and consumed results, using pre-edge values.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      if (in_valid && in_ready) exp_q.push_back({ref_shift(in_operand, in_shamt, in_op), in_tag});
      if (out_valid && out_ready) begin
        got_q.push_back({out_result, out_tag});
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  // Present a request and hold it until accepted (bounded); returns at posedge+1.
  task automatic push_req(input logic [31:0] opnd, input logic [4:0] s, input logic op,
                          input logic [TAG_W-1:0] tag);
    int n;
    in_operand = opnd;
    in_shamt   = s;
    in_op      = op;
    in_tag     = tag;
    in_valid   = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles (tag %0d)", n, tag);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 60) begin
      @(posedge clock);
      #1;
      k++;
    end
    total++;
    if (got_q.size() != n) begin
      bad++;
      $display("FAIL result_count: got %0d results, want %0d", got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_operand = '0; in_shamt = '0; in_op = 1'b0; in_tag = '0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (out_result !== 32'h0) begin bad++; $display("FAIL rst_out_result: got %h want 0", out_result); end
    total++; if (out_tag !== '0) begin bad++; $display("FAIL rst_out_tag: got %h want 0", out_tag); end
    total++; if (count !== '0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
    total++;
    if ({sh_data_operand, sh_ctrl_shiftamt, sh_op} !== 38'h0) begin
      bad++;
      $display("FAIL rst_sh: got %h/%h/%b want 0", sh_data_operand, sh_ctrl_shiftamt, sh_op);
    end
    #3 reset = 1'b1;
    @(posedge clock);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    total++; if (count !== '0) begin bad++; $display("FAIL idle_count: got %0d want 0", count); end
  endtask

  task automatic test_single_sll();
    clear_queues();
    out_ready = 1'b1;
    push_req(32'h0000_0001, 5'd31, 1'b0, 4'h3);
    total++; if (count !== 1) begin bad++; $display("FAIL sll_count: got %0d want 1", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sll_early_valid: got %b want 0", out_valid); end
    total++;
    if (sh_data_operand !== 32'h1 || sh_ctrl_shiftamt !== 5'd31 || sh_op !== 1'b0) begin
      bad++;
      $display("FAIL sll_sh_drive: got %h/%0d/%b want 1/31/0", sh_data_operand, sh_ctrl_shiftamt,
               sh_op);
    end
    @(posedge clock);
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sll_valid: got %b want 1", out_valid); end
    total++; if (out_result !== 32'h8000_0000) begin bad++; $display("FAIL sll_result: got %h want 80000000", out_result); end
    total++; if (out_tag !== 4'h3) begin bad++; $display("FAIL sll_tag: got %h want 3", out_tag); end
    @(posedge clock);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sll_valid_fall: got %b want 0", out_valid); end
  endtask

  task automatic test_sra_zero();
    clear_queues();
    out_ready = 1'b1;
    push_req(32'h8000_0000, 5'd4, 1'b1, 4'h5);
    @(posedge clock);
    #1;
    total++; if (out_result !== 32'hF800_0000) begin bad++; $display("FAIL sra_result: got %h want f8000000", out_result); end
    total++; if (out_tag !== 4'h5 || out_valid !== 1'b1) begin bad++; $display("FAIL sra_tag: got %h/%b want 5/1", out_tag, out_valid); end
    push_req(32'h1234_5678, 5'd0, 1'b0, 4'h6);
    @(posedge clock);
    #1;
    total++; if (out_result !== 32'h1234_5678) begin bad++; $display("FAIL zero_shift_result: got %h want 12345678", out_result); end
    total++; if (out_tag !== 4'h6) begin bad++; $display("FAIL zero_shift_tag: got %h want 6", out_tag); end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_full_backpressure();
    clear_queues();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      push_req($urandom, 5'($urandom_range(0, 31)), 1'($urandom), 4'(i));
    end
    total++; if (out_valid !== 1'b1 || out_tag !== 4'h1) begin bad++; $display("FAIL full_held: got valid %b tag %h want 1/1", out_valid, out_tag); end
    total++; if (count !== 2) begin bad++; $display("FAIL full_count: got %0d want 2", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    total++; if (out_result !== exp_q[0][35:4]) begin bad++; $display("FAIL full_result: got %h want %h", out_result, exp_q[0][35:4]); end
    in_operand = $urandom; in_shamt = 5'($urandom); in_op = 1'($urandom); in_tag = 4'h4;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      total++;
      if (in_ready !== 1'b0 || exp_q.size() != 3 || out_tag !== 4'h1 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall: got in_ready %b accepted %0d tag %h valid %b want 0/3/1/1",
                 in_ready, exp_q.size(), out_tag, out_valid);
      end
    end
    out_ready = 1'b1;
    push_req(in_operand, in_shamt, in_op, 4'h4);
    wait_got(4);
    for (int i = 0; i < 4 && i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || got_q[i][3:0] !== 4'(i + 1)) begin
        bad++;
        $display("FAIL drain_order[%0d]: got %h want %h (tag %0d)", i, got_q[i], exp_q[i], i + 1);
      end
    end
    repeat (2) @(posedge clock);
    #1;
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL drain_dup: got %0d results want 4", got_q.size()); end
  endtask

  task automatic test_streaming();
    clear_queues();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_operand = $urandom;
      in_shamt   = 5'($urandom);
      in_op      = 1'($urandom);
      in_tag     = 4'(i);
      in_valid   = 1'b1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
      @(posedge clock);
      #1;
      total++; if (count > 1) begin bad++; $display("FAIL stream_count[%0d]: got %0d want <=1", i, count); end
    end
    in_valid = 1'b0;
    wait_got(16);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || got_cyc[i] != got_cyc[0] + i) begin
        bad++;
        $display("FAIL stream_result[%0d]: got %h at cyc %0d want %h at cyc %0d", i, got_q[i],
                 got_cyc[i], exp_q[i], got_cyc[0] + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      push_req($urandom, 5'($urandom), 1'($urandom), 4'(i + 8));
    end
    total++; if (count !== 2 || out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre: got count %0d valid %b want 2/1", count, out_valid); end
    #3 reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || count !== '0) begin bad++; $display("FAIL mid_async: got valid %b count %0d want 0/0", out_valid, count); end
    total++; if (out_result !== 32'h0 || in_ready !== 1'b1) begin bad++; $display("FAIL mid_result: got %h ready %b want 0/1", out_result, in_ready); end
    #2 reset = 1'b1;
    clear_queues();
    out_ready = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    total++;
    if (got_q.size() != 0 || out_valid !== 1'b0 || count !== '0) begin
      bad++;
      $display("FAIL mid_stale: got %0d results valid %b count %0d want 0/0/0", got_q.size(),
               out_valid, count);
    end
  endtask

  initial begin
    test_reset();
    test_single_sll();
    test_sra_zero();
    test_full_backpressure();
    test_streaming();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Registered issue/retire stage wrapped around the combinational shifter datapath (SLL/SRA).
- Upstream producers push shift requests (operand, amount, op, tag) into a small FIFO over a valid/ready handshake.
- The FIFO head drives the shifter inputs from registers. The shifter's combinational result is captured into an output register presented to the consumer over a second valid/ready handshake.
- Isolates the shifter's long mux chain between two register boundaries.

Parameters:
- DEPTH, 2, request FIFO entries; power of two, 2..8.
- TAG_W, 4, width of the opaque request tag carried alongside each request.

Ports:
- clock  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (assert = 0); deassertion is synchronised externally.
- in_valid  input  1  request present.
- in_ready  output  1  stage can accept a request this cycle.
- in_operand  input  32  value to shift.
- in_shamt  input  5  shift amount 0..31.
- in_op  input  1  0 = SLL, 1 = SRA.
- in_tag  input  TAG_W  opaque tag, returned with the result.
- sh_data_operand  output  32  to shifter data operand.
- sh_ctrl_shiftamt  output  5  to shifter shift amount.
- sh_op  output  1  to shifter/result mux select.
- sh_result  input  32  combinational shifter result for the current sh_* inputs.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_result  output  32  shifted value.
- out_tag  output  TAG_W  tag of the request that produced out_result.
- count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset = 0, asynchronous):
  - FIFO pointers and count go to 0.
  - out_valid = 0; out_result = 0; out_tag = 0.
  - sh_* outputs = 0.
  - in_ready = 1 once reset = 1.
  - Reset mid-operation discards all queued and held results; no partial result is ever emitted.
- Push: occurs when in_valid & in_ready at a rising edge. {in_operand, in_shamt, in_op, in_tag} is written at the tail.
  - in_ready = (count < DEPTH). It is a registered-state function only, with no combinational path from out_ready or in_valid.
- Shifter drive: sh_* equal the FIFO head fields whenever count > 0. When count = 0 they hold their last value and are don't-care.
- Retire: head_valid = (count > 0). out_load = head_valid & (!out_valid | out_ready).
  - On out_load: out_result <= sh_result, out_tag <= head tag, out_valid <= 1, and the head is popped.
- Out drain: if out_valid & out_ready & !out_load, then out_valid <= 0; out_result and out_tag hold.
- Simultaneous push and pop: the count is unchanged and both take effect. A push is never refused because a pop happens in the same cycle; in_ready is computed from the pre-edge count.
- Full (count = DEPTH): in_ready = 0. in_valid is ignored and the producer must hold its request stable.
- Empty (count = 0) with out_ready = 1: out_valid falls the cycle after the last handshake.
- Pointer wrap-around: modulo DEPTH, with no bubble on wrap.
- Latency: a request pushed at edge k is retired at edge k+1 at the earliest (out_valid visible after edge k+1), provided the output register is free. Throughput is 1 request/clock when out_ready is held at 1.
- Ordering: strict FIFO; results leave in push order with matching tags.
- Back-pressure: out_valid, out_result and out_tag hold stable while out_valid & !out_ready. Requests accumulate up to DEPTH entries, plus 1 held in the output register.
- Arithmetic: the stage performs no arithmetic on data. Shift amount 0 must pass the operand unchanged through the external shifter, and the stage must not special-case it.

Test Plan:
- Reset/idle: hold reset = 0 for 3 cycles, then release. Required: out_valid = 0, out_result = 0, count = 0, in_ready = 1, sh_* = 0.
- Single SLL: push operand 0x00000001, shamt 31, op 0, tag 0x3 at edge k with out_ready = 1. Required: out_valid = 1 after edge k+1 with out_result = 0x80000000 and out_tag = 0x3; out_valid = 0 after edge k+2.
- Single SRA and zero shift:
  - Push 0x80000000, shamt 4, op 1 → 0xF8000000.
  - Push 0x12345678, shamt 0, op 0 → 0x12345678.
- Full and back-pressure: hold out_ready = 0 and push 4 requests (tags 1..4). Required:
  - After 3 pushes: 1 result held, count = 2, in_ready = 0.
  - The 4th request is stalled until out_ready = 1.
  - Outputs then emerge with tags 1, 2, 3, 4 in order, with no duplicates.
- Streaming with simultaneous push/pop: out_ready = 1, push 16 back-to-back random requests. Required:
  - in_ready stays 1 and count stays ≤ 1.
  - 16 results are produced at 1/cycle, each bit-exact against the bench shift model.
- Reset mid-operation: with count = 2 and out_valid = 1, pulse reset = 0 asynchronously between edges. Required: out_valid and count drop immediately; no stale result appears after release.
